// File: rtl/meas_done_ctrl.sv
// meas_done_ctrl
//
// Measurement-completion controller for mLingua sample benches. After `en`
// rises it waits out a settling interval, then counts `valid` strobes (and
// the errors they qualify) until the measurement window closes or a watchdog
// expires. The sticky `done` flag drives one bit of the finish monitor's input
// vector.
//
// Parameters:
//   N_SETTLE  - cycles ignored after the `en` rise (0 skips settling)
//   N_MEAS    - qualified strobes that close the window (>= 1)
//   N_TIMEOUT - watchdog limit in cycles from the `en` rise (0 disables it)
//   CNT_W     - width of all counters and count outputs (>= 2)
//
// Ports:
//   clk      in   rising-edge sampling clock
//   rstb     in   asynchronous active-low reset (released synchronously here)
//   en       in   level; a rising edge starts a run, low aborts to IDLE
//   valid    in   one-cycle measurement strobe
//   err      in   error flag, only meaningful together with `valid`
//   done     out  sticky completion flag
//   pass     out  1 iff done, no counted error and no timeout
//   timeout  out  sticky watchdog-expired flag
//   meas_cnt out  qualified strobes counted this run (saturating)
//   err_cnt  out  qualified errors counted this run (saturating)
//
// Build option:
//   MEAS_DONE_ABORT_ON_ERR_EN - when defined, the first qualified error in the
//   measurement window ends the run immediately (done=1, pass=0). When not
//   defined, errors are only counted.

module meas_done_ctrl #(
  parameter int unsigned N_SETTLE  = 100,
  parameter int unsigned N_MEAS    = 1000,
  parameter int unsigned N_TIMEOUT = 1000000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             valid,
  input  logic             err,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] meas_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_MEAS   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Settle counter value on the last settling cycle. Unused when N_SETTLE=0.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(N_SETTLE) - CNT_ONE;
  localparam logic [CNT_W-1:0] MEAS_LIM    = CNT_W'(N_MEAS);
  localparam logic [CNT_W-1:0] WD_LIM      = CNT_W'(N_TIMEOUT);
  localparam bit               SETTLE_EN   = (N_SETTLE != 0);
  localparam bit               WD_EN       = (N_TIMEOUT != 0);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release waits two edges so no
  // flop leaves reset on a clock edge that races the rstb deassertion.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic             en_q;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             en_rise;
  logic [CNT_W-1:0] wd_inc;
  logic [CNT_W-1:0] meas_inc;
  logic             wd_hit;
  logic             win_full;
  logic             err_abort;

  assign en_rise  = en & ~en_q;
  assign wd_inc   = sat_inc(wd_q);
  assign meas_inc = sat_inc(meas_q);
  assign wd_hit   = WD_EN && (wd_inc == WD_LIM);
  assign win_full = valid && (meas_inc == MEAS_LIM);

`ifdef MEAS_DONE_ABORT_ON_ERR_EN
  assign err_abort = valid & err;
`else
  assign err_abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    wd_d      = wd_q;
    meas_d    = meas_q;
    errc_d    = errc_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        // Counters are held at zero here, so entry into a run starts clean.
        settle_d  = CNT_ZERO;
        wd_d      = CNT_ZERO;
        meas_d    = CNT_ZERO;
        errc_d    = CNT_ZERO;
        timeout_d = 1'b0;
        if (en_rise) begin
          state_d = SETTLE_EN ? ST_SETTLE : ST_MEAS;
        end
      end

      ST_SETTLE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = sat_inc(settle_q);
          wd_d     = wd_inc;
          if (wd_hit) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else if (settle_q == SETTLE_LAST) begin
            state_d = ST_MEAS;
          end
        end
      end

      ST_MEAS: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
          // The strobe on the closing edge is always counted, even when the
          // watchdog expires on the same edge.
          if (valid) begin
            meas_d = meas_inc;
            if (err) begin
              errc_d = sat_inc(errc_q);
            end
          end
          if (wd_hit) begin
            timeout_d = 1'b1;
          end
          if (wd_hit || win_full || err_abort) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving a run clears the counts so IDLE always presents zeros.
    if (state_d == ST_IDLE) begin
      settle_d  = CNT_ZERO;
      wd_d      = CNT_ZERO;
      meas_d    = CNT_ZERO;
      errc_d    = CNT_ZERO;
      timeout_d = 1'b0;
    end

    done_d = (state_d == ST_DONE);
    pass_d = done_d && (errc_d == CNT_ZERO) && !timeout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      // A level already high when reset releases is not treated as a rise.
      en_q      <= 1'b1;
      settle_q  <= CNT_ZERO;
      wd_q      <= CNT_ZERO;
      meas_q    <= CNT_ZERO;
      errc_q    <= CNT_ZERO;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en;
      settle_q  <= settle_d;
      wd_q      <= wd_d;
      meas_q    <= meas_d;
      errc_q    <= errc_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign meas_cnt = meas_q;
  assign err_cnt  = errc_q;

endmodule

// File: tb/tb_meas_done_ctrl.sv
// Testbench for meas_done_ctrl: N_SETTLE=4, N_MEAS=8, N_TIMEOUT=20, CNT_W=16.
// Each run pushes its hand-computed result onto a scoreboard; a monitor pops
// and compares whenever `done` rises. Edge k counts clock edges from the one
// that samples the `en` rise (edge 0).

module tb_meas_done_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned NM = 8;
  localparam int unsigned NT = 20;
  localparam int unsigned CW = 16;

  logic          clk   = 1'b0;
  logic          rstb  = 1'b1;
  logic          en    = 1'b0;
  logic          valid = 1'b0;
  logic          err   = 1'b0;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] meas_cnt;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  meas_done_ctrl #(
    .N_SETTLE (NS),
    .N_MEAS   (NM),
    .N_TIMEOUT(NT),
    .CNT_W    (CW)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en),
    .valid   (valid),
    .err     (err),
    .done    (done),
    .pass    (pass),
    .timeout (timeout),
    .meas_cnt(meas_cnt),
    .err_cnt (err_cnt)
  );

  typedef struct {
    int done_edge;
    int meas;
    int errs;
    int pass_e;
    int to_e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  logic done_prev = 1'b0;

  function automatic exp_t mk(input int k, input int m, input int e, input int p, input int t);
    exp_t r;
    r.done_edge = k;
    r.meas      = m;
    r.errs      = e;
    r.pass_e    = p;
    r.to_e      = t;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on each rising done; pass must stay low otherwise.
  always @(negedge clk) begin
    if (rstb) begin
      if (!done) begin
        check("pass_while_not_done", pass, 0);
      end else if (!done_prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required no completion");
        end else begin
          mon_e = sb.pop_front();
          check("done_edge", cyc - start_cyc - 1, mon_e.done_edge);
          check("meas_cnt", meas_cnt, mon_e.meas);
          check("err_cnt", err_cnt, mon_e.errs);
          check("pass", pass, mon_e.pass_e);
          check("timeout", timeout, mon_e.to_e);
        end
      end
    end
    done_prev <= done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise en (previously low) and play the masks until done or budget expires.
  task automatic run_window(input logic [63:0] vmask, input logic [63:0] emask, input exp_t e);
    bit got;
    got = 1'b0;
    sb.push_back(e);
    start_cyc = cyc;
    for (int k = 0; k < 48 && !got; k++) begin
      en    = 1'b1;
      valid = vmask[k];
      err   = emask[k];
      step();
      if (k == 2) check("done_low_in_run", done, 0);
      if (done) got = 1'b1;
    end
    valid = 1'b0;
    err   = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL window_no_done: got done=0 after 48 edges, required done=1");
      void'(sb.pop_back());
    end
  endtask

  // Drop en for one edge: DONE -> IDLE with everything cleared.
  task automatic end_run();
    en = 1'b0;
    step();
    check("idle_done", done, 0);
    check("idle_meas_cnt", meas_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_timeout", timeout, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_meas_cnt"}, meas_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  logic [63:0] all_ones;
  logic [63:0] err_pat;
  logic [63:0] late_pat;

  initial begin
    all_ones = '1;
    err_pat  = 64'h884;     // edge 2 (settling, ignored), edges 7 and 11
    late_pat = 64'h1FE000;  // strobes on edges 13..20

    #2 rstb = 1'b0;
    #1 check_all_zero("reset");
    step();
    step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Clean run: strobes every edge, first five ignored.
    run_window(all_ones, 64'h0, mk(12, 8, 0, 1, 0));
    end_run();

    // Errors on the 3rd and 7th counted strobes.
`ifdef MEAS_DONE_ABORT_ON_ERR_EN
    run_window(all_ones, err_pat, mk(7, 3, 1, 0, 0));
`else
    run_window(all_ones, err_pat, mk(12, 8, 2, 0, 0));
`endif
    end_run();

    // No strobes (err alone is not qualified): watchdog ends the run.
    run_window(64'h0, all_ones, mk(20, 0, 0, 0, 1));
    end_run();

    // Final strobe coincides with watchdog expiry.
    run_window(late_pat, 64'h0, mk(20, 8, 0, 0, 1));
    end_run();

    // en dropped mid-MEAS: back to IDLE with counts cleared.
    for (int k = 0; k < 7; k++) begin
      en    = 1'b1;
      valid = 1'b1;
      step();
    end
    check("abort_pre_meas_cnt", meas_cnt, 2);
    en = 1'b0;
    step();
    check("abort_meas_cnt", meas_cnt, 0);
    check("abort_done", done, 0);
    valid = 1'b0;
    step();

    // Reset mid-MEAS with meas_cnt=5.
    for (int k = 0; k < 10; k++) begin
      en    = 1'b1;
      valid = 1'b1;
      step();
    end
    check("pre_reset_meas_cnt", meas_cnt, 5);
    #2 rstb = 1'b0;
    #1 check_all_zero("async_reset");
    step();
    step();
    rstb = 1'b1;
    // en stays high: no new rise, so nothing may start.
    for (int i = 0; i < 8; i++) step();
    check("no_restart_done", done, 0);
    check("no_restart_meas_cnt", meas_cnt, 0);
    valid = 1'b0;
    en    = 1'b0;
    step();

    // Fresh run after the reset.
    run_window(all_ones, 64'h0, mk(12, 8, 0, 1, 0));
    end_run();
    step();

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
